bfly_addsub: RTL and testbench

BFLY_ADDSUB -- requirements
Module: bfly_addsub

---
 rtl/bfly_addsub.sv | 91 +++++++++
 tb/tb_bfly_addsub.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bfly_addsub.sv
// rtl/bfly_addsub.sv - NTT butterfly modular add/subtract stage, 2-deep valid/ready pipeline
// S1 forms raw x+t and x-t; S2 folds them back into [0, q) and feeds the outputs.
module bfly_addsub #(
  parameter int BIT_WIDTH = 54
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_WIDTH-1:0] q_in,
  input  logic                 q_load,
  input  logic [BIT_WIDTH-1:0] x_in,
  input  logic [BIT_WIDTH-1:0] t_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] sum_out,
  output logic [BIT_WIDTH-1:0] diff_out,
  output logic                 busy,
  output logic                 q_load_err,
  output logic [31:0]          out_cnt
);

  logic [BIT_WIDTH-1:0] q_reg;
  logic                 s1_valid;
  logic                 s2_valid;
  logic [BIT_WIDTH:0]   s1_s;
  logic [BIT_WIDTH:0]   s1_d;
  logic                 s1_adv;
  logic                 s2_adv;
  logic [BIT_WIDTH-1:0] sum_nxt;
  logic [BIT_WIDTH-1:0] diff_nxt;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign busy      = s1_valid || s2_valid;
  assign out_valid = s2_valid;

  // Corrections are done in BIT_WIDTH bits; the dropped carry cannot affect the truncated result.
  always_comb begin
    sum_nxt  = s1_s[BIT_WIDTH-1:0];
    diff_nxt = s1_d[BIT_WIDTH-1:0];
    if (s1_s >= {1'b0, q_reg}) begin
      sum_nxt = s1_s[BIT_WIDTH-1:0] - q_reg;
    end
    if (s1_d[BIT_WIDTH]) begin
      diff_nxt = s1_d[BIT_WIDTH-1:0] + q_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg      <= '0;
      q_load_err <= 1'b0;
      s1_valid   <= 1'b0;
      s1_s       <= '0;
      s1_d       <= '0;
      s2_valid   <= 1'b0;
      sum_out    <= '0;
      diff_out   <= '0;
      out_cnt    <= '0;
    end else begin
      // The modulus may only change while nothing in flight depends on it.
      if (q_load) begin
        if (busy) begin
          q_load_err <= 1'b1;
        end else begin
          q_reg <= q_in;
        end
      end
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_s <= {1'b0, x_in} + {1'b0, t_in};
          s1_d <= {1'b0, x_in} - {1'b0, t_in};
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          sum_out  <= sum_nxt;
          diff_out <= diff_nxt;
        end
      end
      if (s2_valid && out_ready) begin
        out_cnt <= out_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_bfly_addsub.sv
// tb/tb_bfly_addsub.sv - randomized self-checking bench for bfly_addsub
// Expected results come from plain modular arithmetic on a queue of accepted operands.
module tb_bfly_addsub;

  localparam int W = 54;
  localparam logic [W-1:0] Q_BIG   = 54'h3F_FFFF_FFFE_D001;
  localparam logic [W-1:0] Q_SMALL = 54'h000_0000_07FF_6001;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  q_in;
  logic          q_load;
  logic [W-1:0]  x_in;
  logic [W-1:0]  t_in;
  logic          in_valid;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum_out;
  logic [W-1:0]  diff_out;
  logic          busy;
  logic          q_load_err;
  logic [31:0]   out_cnt;

  int            n_chk = 0;
  int            n_fail = 0;
  logic [W-1:0]  q_model;
  logic [W-1:0]  exp_s[$];
  logic [W-1:0]  exp_d[$];

  always #5 clk = ~clk;

  bfly_addsub #(.BIT_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .q_in(q_in), .q_load(q_load),
    .x_in(x_in), .t_in(t_in), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum_out(sum_out), .diff_out(diff_out), .busy(busy),
    .q_load_err(q_load_err), .out_cnt(out_cnt)
  );

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, input logic [W-1:0] t,
                                           input logic [W-1:0] q);
    logic [63:0] r;
    r = (64'(x) + 64'(t)) % 64'(q);
    return r[W-1:0];
  endfunction

  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, input logic [W-1:0] t,
                                           input logic [W-1:0] q);
    logic [63:0] r;
    r = (64'(x) + 64'(q) - 64'(t)) % 64'(q);
    return r[W-1:0];
  endfunction

  function automatic void push_ref(input logic [W-1:0] x, input logic [W-1:0] t);
    exp_s.push_back(mod_add(x, t, q_model));
    exp_d.push_back(mod_sub(x, t, q_model));
  endfunction

  // Drive one cycle, observe at the falling edge, return just after the next rising edge.
  task automatic cycle(input logic iv, input logic [W-1:0] x, input logic [W-1:0] t,
                       input logic ordy, output logic rdy, output logic ov,
                       output logic [W-1:0] s, output logic [W-1:0] d);
    in_valid = iv; x_in = x; t_in = t; out_ready = ordy;
    @(negedge clk);
    rdy = in_ready; ov = out_valid; s = sum_out; d = diff_out;
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; in_valid = 1'b0; q_load = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    q_model = '0;
    exp_s.delete(); exp_d.delete();
  endtask

  task automatic load_q(input logic [W-1:0] q);
    q_load = 1'b1; q_in = q; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    q_load = 1'b0;
    q_model = q;
  endtask

  task automatic test_reset();
    apply_reset();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0h expected 0", out_valid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h expected 0", busy); end
    n_chk++; if (out_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_out_cnt: got %0h expected 0", out_cnt); end
    n_chk++; if (sum_out !== '0) begin n_fail++; $display("FAIL reset_sum: got %0h expected 0", sum_out); end
    n_chk++; if (diff_out !== '0) begin n_fail++; $display("FAIL reset_diff: got %0h expected 0", diff_out); end
    n_chk++; if (q_load_err !== 1'b0) begin n_fail++; $display("FAIL reset_q_load_err: got %0h expected 0", q_load_err); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0h expected 1", in_ready); end
  endtask

  task automatic test_vectors();
    logic [W-1:0] xs[3];
    logic [W-1:0] ts[3];
    logic [W-1:0] es[3];
    logic [W-1:0] ed[3];
    logic rdy, ov;
    logic [W-1:0] s, d;
    apply_reset();
    load_q(Q_BIG);
    xs[0] = Q_BIG - 54'd1; ts[0] = Q_BIG - 54'd1; es[0] = 54'h3F_FFFF_FFFE_CFFF; ed[0] = 54'd0;
    xs[1] = 54'd0;         ts[1] = 54'd1;         es[1] = 54'd1;                 ed[1] = Q_BIG - 54'd1;
    xs[2] = 54'd5;         ts[2] = Q_BIG - 54'd5; es[2] = 54'd0;                 ed[2] = 54'd10;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, xs[i], ts[i], 1'b1, rdy, ov, s, d);
      n_chk++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL vec%0d_accept: got %0h expected 1", i, rdy); end
      cycle(1'b0, '0, '0, 1'b1, rdy, ov, s, d);
      n_chk++; if (ov !== 1'b0) begin n_fail++; $display("FAIL vec%0d_early_valid: got %0h expected 0", i, ov); end
      cycle(1'b0, '0, '0, 1'b1, rdy, ov, s, d);
      n_chk++;
      if ({ov, s, d} !== {1'b1, es[i], ed[i]}) begin
        n_fail++;
        $display("FAIL vec%0d_result: got v=%0h sum=%0h diff=%0h expected v=1 sum=%0h diff=%0h", i, ov, s, d, es[i], ed[i]);
      end
    end
    for (int c = 0; c < 5; c++) begin
      cycle(c < 3, xs[c % 3], ts[c % 3], 1'b1, rdy, ov, s, d);
      if (c >= 2) begin
        n_chk++;
        if ({ov, s, d} !== {1'b1, es[c-2], ed[c-2]}) begin
          n_fail++;
          $display("FAIL b2b%0d_result: got v=%0h sum=%0h diff=%0h expected v=1 sum=%0h diff=%0h", c-2, ov, s, d, es[c-2], ed[c-2]);
        end
      end
    end
    n_chk++; if (out_cnt !== 32'd6) begin n_fail++; $display("FAIL vec_out_cnt: got %0d expected 6", out_cnt); end
  endtask

  task automatic test_back_to_back_stall();
    logic rdy, ov;
    logic [W-1:0] s, d, s0, d0;
    logic [W-1:0] cx;
    apply_reset();
    load_q(Q_BIG);
    cx = Q_BIG - 54'd1;
    cycle(1'b1, 54'd1, 54'd2, 1'b0, rdy, ov, s, d);
    n_chk++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL stall_accept_a: got %0h expected 1", rdy); end
    push_ref(54'd1, 54'd2);
    cycle(1'b1, 54'd10, 54'd3, 1'b0, rdy, ov, s, d);
    n_chk++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL stall_accept_b: got %0h expected 1", rdy); end
    push_ref(54'd10, 54'd3);
    cycle(1'b1, cx, 54'd1, 1'b0, rdy, ov, s0, d0);
    n_chk++; if ({rdy, ov} !== 2'b01) begin n_fail++; $display("FAIL stall_full: got rdy=%0h v=%0h expected rdy=0 v=1", rdy, ov); end
    n_chk++;
    if ({s0, d0} !== {exp_s[0], exp_d[0]}) begin
      n_fail++; $display("FAIL stall_head: got sum=%0h diff=%0h expected sum=%0h diff=%0h", s0, d0, exp_s[0], exp_d[0]);
    end
    cycle(1'b1, cx, 54'd1, 1'b0, rdy, ov, s, d);
    n_chk++;
    if ({rdy, s, d} !== {1'b0, s0, d0}) begin
      n_fail++; $display("FAIL stall_stable: got rdy=%0h sum=%0h diff=%0h expected rdy=0 sum=%0h diff=%0h", rdy, s, d, s0, d0);
    end
    cycle(1'b1, cx, 54'd1, 1'b1, rdy, ov, s, d);
    n_chk++; if ({rdy, ov} !== 2'b11) begin n_fail++; $display("FAIL stall_release: got rdy=%0h v=%0h expected rdy=1 v=1", rdy, ov); end
    push_ref(cx, 54'd1);
    if (ov) begin
      n_chk++;
      if ({s, d} !== {exp_s.pop_front(), exp_d.pop_front()}) begin
        n_fail++; $display("FAIL stall_order0: got sum=%0h diff=%0h", s, d);
      end
    end
    for (int c = 0; c < 5; c++) begin
      cycle(1'b0, '0, '0, 1'b1, rdy, ov, s, d);
      if (ov) begin
        n_chk++;
        if (exp_s.size() == 0) begin
          n_fail++; $display("FAIL stall_extra: got sum=%0h diff=%0h expected no output", s, d);
        end else if ({s, d} !== {exp_s[0], exp_d[0]}) begin
          n_fail++; $display("FAIL stall_order: got sum=%0h diff=%0h expected sum=%0h diff=%0h", s, d, exp_s[0], exp_d[0]);
          void'(exp_s.pop_front()); void'(exp_d.pop_front());
        end else begin
          void'(exp_s.pop_front()); void'(exp_d.pop_front());
        end
      end
    end
    n_chk++; if (exp_s.size() != 0) begin n_fail++; $display("FAIL stall_missing: got %0d left expected 0", exp_s.size()); end
    n_chk++; if (out_cnt !== 32'd3) begin n_fail++; $display("FAIL stall_out_cnt: got %0d expected 3", out_cnt); end
  endtask

  task automatic test_q_load_err();
    logic rdy, ov;
    logic [W-1:0] s, d;
    apply_reset();
    load_q(Q_BIG);
    n_chk++; if (q_load_err !== 1'b0) begin n_fail++; $display("FAIL qerr_initial: got %0h expected 0", q_load_err); end
    cycle(1'b1, 54'd0, 54'd1, 1'b1, rdy, ov, s, d);
    q_load = 1'b1; q_in = Q_SMALL;
    cycle(1'b0, '0, '0, 1'b1, rdy, ov, s, d);
    q_load = 1'b0;
    n_chk++; if (q_load_err !== 1'b1) begin n_fail++; $display("FAIL qerr_set: got %0h expected 1", q_load_err); end
    cycle(1'b0, '0, '0, 1'b1, rdy, ov, s, d);
    cycle(1'b1, 54'd0, 54'd1, 1'b1, rdy, ov, s, d);
    cycle(1'b0, '0, '0, 1'b1, rdy, ov, s, d);
    cycle(1'b0, '0, '0, 1'b1, rdy, ov, s, d);
    n_chk++;
    if ({ov, d} !== {1'b1, Q_BIG - 54'd1}) begin
      n_fail++; $display("FAIL qerr_q_kept: got v=%0h diff=%0h expected v=1 diff=%0h", ov, d, Q_BIG - 54'd1);
    end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL qerr_drained: got %0h expected 0", busy); end
    load_q(Q_SMALL);
    n_chk++; if (q_load_err !== 1'b1) begin n_fail++; $display("FAIL qerr_sticky: got %0h expected 1", q_load_err); end
    cycle(1'b1, 54'd0, 54'd1, 1'b1, rdy, ov, s, d);
    cycle(1'b0, '0, '0, 1'b1, rdy, ov, s, d);
    cycle(1'b0, '0, '0, 1'b1, rdy, ov, s, d);
    n_chk++;
    if ({ov, d} !== {1'b1, 54'h7FF6000}) begin
      n_fail++; $display("FAIL qerr_reload: got v=%0h diff=%0h expected v=1 diff=7ff6000", ov, d);
    end
  endtask

  task automatic test_random();
    logic rdy, ov, iv, ordy, hold;
    logic [W-1:0] s, d, ps, pd, cx, ct;
    int sent, recv, cyc;
    apply_reset();
    load_q(Q_SMALL);
    sent = 0; recv = 0; cyc = 0; hold = 1'b0; ps = '0; pd = '0;
    cx = W'($urandom_range(32'(Q_SMALL - 54'd1)));
    ct = W'($urandom_range(32'(Q_SMALL - 54'd1)));
    while (recv < 4096 && cyc < 40000) begin
      iv   = (sent < 4096) && ($urandom_range(3) != 0);
      ordy = ($urandom_range(3) != 0);
      cycle(iv, cx, ct, ordy, rdy, ov, s, d);
      cyc++;
      if (hold) begin
        n_chk++;
        if ({ov, s, d} !== {1'b1, ps, pd}) begin
          n_fail++; $display("FAIL rand_stable: got v=%0h sum=%0h diff=%0h expected v=1 sum=%0h diff=%0h", ov, s, d, ps, pd);
        end
      end
      if (iv && rdy) begin
        push_ref(cx, ct);
        sent++;
        cx = ($urandom_range(15) == 0) ? Q_SMALL - 54'd1 : W'($urandom_range(32'(Q_SMALL - 54'd1)));
        ct = ($urandom_range(15) == 0) ? Q_SMALL - 54'd1 : W'($urandom_range(32'(Q_SMALL - 54'd1)));
      end
      if (ov && ordy) begin
        n_chk++;
        if (exp_s.size() == 0) begin
          n_fail++; $display("FAIL rand_extra: got sum=%0h diff=%0h expected no output", s, d);
        end else begin
          if ({s, d} !== {exp_s[0], exp_d[0]}) begin
            n_fail++; $display("FAIL rand_result%0d: got sum=%0h diff=%0h expected sum=%0h diff=%0h", recv, s, d, exp_s[0], exp_d[0]);
          end
          void'(exp_s.pop_front()); void'(exp_d.pop_front());
        end
        recv++;
      end
      hold = ov && !ordy; ps = s; pd = d;
    end
    n_chk++; if (recv != 4096) begin n_fail++; $display("FAIL rand_count: got %0d expected 4096", recv); end
    n_chk++; if (out_cnt !== 32'd4096) begin n_fail++; $display("FAIL rand_out_cnt: got %0d expected 4096", out_cnt); end
  endtask

  task automatic test_reset_midstream();
    logic rdy, ov;
    logic [W-1:0] s, d;
    cycle(1'b1, 54'd3, 54'd5, 1'b0, rdy, ov, s, d);
    n_chk++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL mid_accept0: got %0h expected 1", rdy); end
    cycle(1'b1, 54'd7, 54'd2, 1'b0, rdy, ov, s, d);
    n_chk++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL mid_accept1: got %0h expected 1", rdy); end
    rst = 1'b1; q_load = 1'b1; q_in = 54'd100; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; q_load = 1'b0; in_valid = 1'b0;
    exp_s.delete(); exp_d.delete();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %0h expected 0", out_valid); end
    n_chk++; if (out_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_out_cnt: got %0d expected 0", out_cnt); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %0h expected 0", busy); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %0h expected 1", in_ready); end
    for (int c = 0; c < 4; c++) begin
      cycle(1'b0, '0, '0, 1'b1, rdy, ov, s, d);
      n_chk++; if (ov !== 1'b0) begin n_fail++; $display("FAIL mid_stale%0d: got v=%0h sum=%0h expected v=0", c, ov, s); end
    end
    // q_reg must have been cleared, not loaded, by the reset edge: 3-5 wraps with q=0.
    cycle(1'b1, 54'd3, 54'd5, 1'b1, rdy, ov, s, d);
    cycle(1'b0, '0, '0, 1'b1, rdy, ov, s, d);
    cycle(1'b0, '0, '0, 1'b1, rdy, ov, s, d);
    n_chk++;
    if ({ov, s, d} !== {1'b1, 54'd8, {W{1'b1}} - 54'd1}) begin
      n_fail++; $display("FAIL mid_q_cleared: got v=%0h sum=%0h diff=%0h expected v=1 sum=8 diff=%0h", ov, s, d, {W{1'b1}} - 54'd1);
    end
  endtask

  initial begin
    rst = 1'b1; q_load = 1'b0; q_in = '0; x_in = '0; t_in = '0;
    in_valid = 1'b0; out_ready = 1'b0; q_model = '0;
    test_reset();
    test_vectors();
    test_back_to_back_stall();
    test_q_load_err();
    test_random();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
